regfile_end_checker: RTL

Synthesizable end-of-test checker for the pipelined processor top level. It counts clock cycles after `start` and triggers on either a programmed cycle limit or a programmed halt PC. It then walks a table of up to `NUM_CHECKS` expected register values through a register-file read port and reports pass/fail, mismatch count and the first failing entry. Testbenches use it as a parametrised, trigger-flexible replacement for hand-written cycle-N register dumps, and it can also be instantiated on an FPGA for self-test.

---
 rtl/checker_pkg.sv | 17 +
 rtl/check_table.sv | 80 ++++++++
 rtl/regfile_end_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/checker_pkg.sv
// Shared types for the end-of-test register checker: FSM state encoding and
// default parameter values used by the checker modules.
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_NUM_CHECKS = 8;
    localparam int DEF_CYC_W      = 32;

endpackage

// File: rtl/check_table.sv
// Expected-value table: one write port, one combinational read port by index.
// Only the valid bits are reset; addr/value contents survive reset.
module check_table
    import checker_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_value,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_value
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
    } entry_t;

    logic [NUM_CHECKS-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]     addr_q  [NUM_CHECKS];
    logic [ADDR_W-1:0]     addr_d  [NUM_CHECKS];
    logic [DATA_W-1:0]     value_q [NUM_CHECKS];
    logic [DATA_W-1:0]     value_d [NUM_CHECKS];
    logic                  wr_hit;
    logic                  rd_hit;
    entry_t                rd_entry;

    // Indices past the end of the table are silently dropped.
    assign wr_hit = wr_en && (32'(wr_idx) < NUM_CHECKS);
    assign rd_hit = 32'(rd_idx) < NUM_CHECKS;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        value_d = value_q;
        if (wr_hit) begin
            valid_d[wr_idx] = wr_valid;
            addr_d[wr_idx]  = wr_addr;
            value_d[wr_idx] = wr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        value_q <= value_d;
    end

    always_comb begin
        rd_entry = '0;
        if (rd_hit) begin
            rd_entry.valid = valid_q[rd_idx];
            rd_entry.addr  = addr_q[rd_idx];
            rd_entry.value = value_q[rd_idx];
        end
    end

    assign rd_valid = rd_entry.valid;
    assign rd_addr  = rd_entry.addr;
    assign rd_value = rd_entry.value;

endmodule

// File: rtl/regfile_end_checker.sv
// End-of-test checker: counts cycles after start, triggers on a cycle limit or
// halt PC, then walks the check table through a register-file read port.
module regfile_end_checker
    import checker_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS,
    parameter int CYC_W      = DEF_CYC_W,
    localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic              halt_en,
    input  logic [DATA_W-1:0] halt_pc,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_value,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data,
    output logic [CYC_W-1:0]  cycle_count,
    output state_t            dbg_state
);

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    cycle_count_q, cycle_count_d;
    logic [CYC_W-1:0]    limit_q, limit_d;
    logic                halt_en_q, halt_en_d;
    logic [DATA_W-1:0]   halt_pc_q, halt_pc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   rf_raddr_q, rf_raddr_d;
    logic                cur_valid_q, cur_valid_d;
    logic [DATA_W-1:0]   cur_value_q, cur_value_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [IDX_W:0]      fail_count_q, fail_count_d;
    logic [IDX_W-1:0]    first_fail_idx_q, first_fail_idx_d;
    logic [DATA_W-1:0]   first_fail_data_q, first_fail_data_d;

    logic                busy_w;
    logic                trig;
    logic                mismatch;
    logic                last_entry;
    logic [IDX_W-1:0]    tbl_rd_idx;
    logic                tbl_valid;
    logic [ADDR_W-1:0]   tbl_addr;
    logic [DATA_W-1:0]   tbl_value;

    assign busy_w = (state_q == ST_COUNT) || (state_q == ST_CHECK);

    check_table #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_we && !busy_w),
        .wr_idx   (cfg_idx),
        .wr_valid (cfg_valid),
        .wr_addr  (cfg_addr),
        .wr_value (cfg_value),
        .rd_idx   (tbl_rd_idx),
        .rd_valid (tbl_valid),
        .rd_addr  (tbl_addr),
        .rd_value (tbl_value)
    );

    // With both triggers disabled the run ends on the first COUNT cycle.
    assign trig = ((limit_q != '0) && (cycle_count_q == limit_q))
               || (halt_en_q && (pc_in == halt_pc_q))
               || ((limit_q == '0) && !halt_en_q);

    assign mismatch   = cur_valid_q && (rf_rdata != cur_value_q);
    assign last_entry = (idx_q == IDX_W'(NUM_CHECKS - 1));
    // The table is read one entry ahead so rf_raddr is a clean register.
    assign tbl_rd_idx = (state_q == ST_CHECK) ? idx_q + IDX_W'(1) : '0;

    always_comb begin
        state_d           = state_q;
        cycle_count_d     = cycle_count_q;
        limit_d           = limit_q;
        halt_en_d         = halt_en_q;
        halt_pc_d         = halt_pc_q;
        idx_d             = idx_q;
        rf_raddr_d        = rf_raddr_q;
        cur_valid_d       = cur_valid_q;
        cur_value_d       = cur_value_q;
        done_d            = done_q;
        pass_d            = pass_q;
        fail_count_d      = fail_count_q;
        first_fail_idx_d  = first_fail_idx_q;
        first_fail_data_d = first_fail_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d           = ST_COUNT;
                    limit_d           = cycle_limit;
                    halt_en_d         = halt_en;
                    halt_pc_d         = halt_pc;
                    cycle_count_d     = CYC_W'(1);
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                    fail_count_d      = '0;
                    first_fail_idx_d  = '0;
                    first_fail_data_d = '0;
                end
            end
            ST_COUNT: begin
                if (trig) begin
                    state_d     = ST_CHECK;
                    idx_d       = '0;
                    rf_raddr_d  = tbl_addr;
                    cur_valid_d = tbl_valid;
                    cur_value_d = tbl_value;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CYC_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + (IDX_W+1)'(1);
                    if (fail_count_q == '0) begin
                        first_fail_idx_d  = idx_q;
                        first_fail_data_d = rf_rdata;
                    end
                end
                if (last_entry) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                    rf_raddr_d  = tbl_addr;
                    cur_valid_d = tbl_valid;
                    cur_value_d = tbl_value;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cycle_count_q     <= '0;
            limit_q           <= '0;
            halt_en_q         <= 1'b0;
            halt_pc_q         <= '0;
            idx_q             <= '0;
            rf_raddr_q        <= '0;
            cur_valid_q       <= 1'b0;
            cur_value_q       <= '0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fail_count_q      <= '0;
            first_fail_idx_q  <= '0;
            first_fail_data_q <= '0;
        end else begin
            state_q           <= state_d;
            cycle_count_q     <= cycle_count_d;
            limit_q           <= limit_d;
            halt_en_q         <= halt_en_d;
            halt_pc_q         <= halt_pc_d;
            idx_q             <= idx_d;
            rf_raddr_q        <= rf_raddr_d;
            cur_valid_q       <= cur_valid_d;
            cur_value_q       <= cur_value_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            fail_count_q      <= fail_count_d;
            first_fail_idx_q  <= first_fail_idx_d;
            first_fail_data_q <= first_fail_data_d;
        end
    end

    assign rf_raddr        = rf_raddr_q;
    assign busy            = busy_w;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail_count      = fail_count_q;
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_data = first_fail_data_q;
    assign cycle_count     = cycle_count_q;
    assign dbg_state       = state_q;

endmodule
